// File: rtl/serial_sipo_receiver_if.sv
// Serial link plus word handshake between a serial source, the SIPO receiver
// and its word consumer. The master modport drives the link side (tb/source/consumer).
interface serial_sipo_receiver_if #(
   parameter int BITS = 8
);
   logic            si;
   logic            shift_en;
   logic            clear;
   logic            ack;
   logic [BITS-1:0] data;
   logic            valid;
   logic            overrun;
   logic            busy;

   modport master (
      output si, shift_en, clear, ack,
      input  data, valid, overrun, busy
   );

   modport slave (
      input  si, shift_en, clear, ack,
      output data, valid, overrun, busy
   );
endinterface

// File: rtl/serial_sipo_receiver.sv
// Serial-in parallel-out receiver: assembles BITS-wide words from a strobed
// serial stream and hands them off with a sticky-overrun valid/ack handshake.
module serial_sipo_receiver #(
   parameter  int BITS      = 8,
   parameter  bit MSB_FIRST = 1'b0,
   localparam int CNT_W     = $clog2(BITS)
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   serial_sipo_receiver_if.slave  bus
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BITS - 1);

   logic [BITS-1:0]  sreg_q, sreg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [BITS-1:0]  data_q, data_d;
   logic             valid_q, valid_d;
   logic             overrun_q, overrun_d;
   logic [BITS-1:0]  shifted;
   logic             done;

   // The shifted value on the final bit already contains the current SI,
   // so it is the completed word itself.
   generate
      if (MSB_FIRST) begin : g_msb
         assign shifted = {sreg_q[BITS-2:0], bus.si};
      end else begin : g_lsb
         assign shifted = {bus.si, sreg_q[BITS-1:1]};
      end
   endgenerate

   assign done = bus.shift_en && !bus.clear && (cnt_q == CNT_LAST);

   always_comb begin
      sreg_d    = sreg_q;
      cnt_d     = cnt_q;
      data_d    = data_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;

      if (bus.clear) begin
         sreg_d    = '0;
         cnt_d     = '0;
         overrun_d = 1'b0;
      end else if (bus.shift_en) begin
         sreg_d = shifted;
         cnt_d  = done ? '0 : cnt_q + CNT_W'(1);
      end

      if (done) begin
         if (!valid_q || bus.ack) begin
            data_d  = shifted;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (bus.ack) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sreg_q    <= '0;
         cnt_q     <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         sreg_q    <= sreg_d;
         cnt_q     <= cnt_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   assign bus.data    = data_q;
   assign bus.valid   = valid_q;
   assign bus.overrun = overrun_q;
   assign bus.busy    = (cnt_q != '0);

endmodule
